ir_key_scheduler: RTL and testbench
===================================

# ir_key_scheduler

Buffers and schedules decoded key codes from the infrared remote receiver (`RemoteController`) toward a single consumer. Each `Ready` pulse's `Tecla` byte is filtered for auto-repeat, queued in a small FIFO and presented on a valid/ack handshake. The consumer (menu/control logic) can therefore stall without losing frames. The block sits directly downstream of `RemoteController` on the same clock.

## Interface

**Parameters**
- `DEPTH`, 4: FIFO entries; power of two, 2..16.
- `HOLD_CYCLES`, 1000: repeat-suppression window in clock cycles, ≥2.

**Ports**
- `Clock` in 1: sole clock, rising edge.
- `Reset` in 1: synchronous, active-high.
- `KeyIn` in 8: key code; connects to `Tecla`.
- `KeyReady` in 1: one-cycle strobe; connects to `Ready`. `KeyIn` is valid in the same cycle.
- `KeyOut` out 8: key code at the FIFO head.
- `KeyValid` out 1: FIFO non-empty.
- `KeyAck` in 1: consumer accepts the head. Acts only while `KeyValid`=1.
- `Count` out clog2(DEPTH)+1: current occupancy, 0..DEPTH.
- `Overflow` out 1: sticky; a key was dropped because the FIFO was full.

## Operation

- **Storage:** DEPTH×8 memory with write pointer, read pointer and occupancy counter. Pointers wrap modulo DEPTH.
- **Input FSM states:**
  - IDLE: counter = 0.
  - HOLD: counter > 0.
  - Counter is `HOLD_CYCLES` wide enough.
- **Strobe handling:** on `KeyReady`=1, the code is classified.
  - **FILTER:** repeat-filter enabled, state is HOLD, and `KeyIn` == last accepted code. The key is discarded, the counter reloads to HOLD_CYCLES-1, and the state stays HOLD.
  - **PUSH:** otherwise, if there is space. Write at the write pointer, write pointer +1, last code ← `KeyIn`, counter ← HOLD_CYCLES-1, state → HOLD.
  - **DROP:** otherwise (full). No write. `Overflow` ← 1. Last code and counter are still updated as in PUSH.
- **Countdown:** in HOLD with no strobe, the counter decrements. The state goes to IDLE on the cycle the counter reaches 0.
- **Pop:** when `KeyValid` && `KeyAck`, read pointer +1 and `Count` −1.
- **Full and pop together:** a push and a pop in the same cycle while full are both accepted. `Count` is unchanged and there is no overflow.
- **Empty and push together:** `KeyAck` is ignored while empty. A same-cycle push is not popped.
- **Arithmetic:** `Count` is next = Count + push − pop and never exceeds DEPTH or goes below 0.
- **`Overflow`:** stays 1 until `Reset`.
- **`Reset` (any cycle, including mid-hold or with a non-empty FIFO):**
  - Pointers, `Count` and counter go to 0; state goes to IDLE.
  - Last code goes to 0x00; `Overflow` goes to 0.
  - FIFO contents are discarded.
  - A `KeyReady` in the reset cycle is ignored.

## Timing

- **Reset values:** `KeyOut`=0x00, `KeyValid`=0, `Count`=0, `Overflow`=0.
- **`Count` and `KeyValid`:**
  - Both are registered; `KeyValid` = (`Count` != 0).
  - Latency from `KeyReady` in cycle N to `KeyValid`=1 in cycle N+1 (FIFO previously empty).
- **`KeyOut`:**
  - Equals the memory at the read pointer.
  - Stable while `KeyValid`=1 and `KeyAck`=0.
  - Updates the cycle after an accepted ack.
  - Is 0x00 while empty.
- **Ack timing:** ack in cycle N with `Count`=1 → `KeyValid`=0 in N+1.
- **Throughput:** back-to-back acks pop one entry per cycle.
- **Hold window:** a repeated key is suppressed if it arrives within HOLD_CYCLES cycles after the previous strobe of that key. Arriving exactly at HOLD_CYCLES cycles or later, it is accepted.

## Configuration

- Macro `IR_REPEAT_FILTER_EN`.
- **Defined:** FILTER classification is active as described.
- **Undefined:**
  - The comparison logic is removed; every strobe is PUSH or DROP.
  - The counter and HOLD state are still implemented, so the FSM is identical.
  - The counter has no effect on outputs.

## Test plan

Parameters for all scenarios: HOLD_CYCLES=8, DEPTH=4.

1. Reset, then strobe 0x01, no ack → cycle after strobe: `KeyValid`=1, `KeyOut`=0x01, `Count`=1. Ack once → `KeyValid`=0, `KeyOut`=0x00.
2. Filter on; strobe 0x16, then 0x16 again 3 cycles later → `Count`=1. Strobe 0x16 again 10 cycles after the second → `Count`=2, both entries 0x16. Macro undefined: the first pair gives `Count`=2.
3. Strobes 0x01, 0x02, 0x03, 0x04, 0x05 (distinct), no ack → `Count`=4, `Overflow`=1. Pop order is 0x01, 0x02, 0x03, 0x04; 0x05 is lost.
4. FIFO full, strobe 0x07 with `KeyAck`=1 in the same cycle → `Count` stays 4, `Overflow`=0, 0x07 is last out.
5. Three entries queued, 0x45 strobed, and `Reset` asserted in the same cycle → next cycle all outputs are at reset values. Strobe 0x45 one cycle later is accepted (not filtered).
6. Ack held high continuously with 4 queued entries → four consecutive pops in 4 cycles, then `KeyValid`=0. Ack while empty → no change.

Source files
------------

// File: rtl/ir_key_scheduler.sv
// Auto-repeat filtered key FIFO between the IR receiver and a valid/ack consumer.
// Optional macro IR_REPEAT_FILTER_EN enables suppression of repeated codes within the hold window.
module ir_key_scheduler #(
    parameter int DEPTH       = 4,
    parameter int HOLD_CYCLES = 1000
) (
    input  logic                     Clock,
    input  logic                     Reset,
    input  logic [7:0]               KeyIn,
    input  logic                     KeyReady,
    output logic [7:0]               KeyOut,
    output logic                     KeyValid,
    input  logic                     KeyAck,
    output logic [$clog2(DEPTH):0]   Count,
    output logic                     Overflow
);

    localparam int PW    = $clog2(DEPTH);
    localparam int CNT_W = PW + 1;
    localparam int HW    = (HOLD_CYCLES > 2) ? $clog2(HOLD_CYCLES) : 1;

    typedef enum logic {
        IDLE,
        HOLD
    } state_t;

    logic [7:0]       mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [HW-1:0]    hold_cnt;
    state_t           state;
    logic             full;
    logic             pop;
    logic             repeat_hit;
    logic             push;
    logic             drop;
    logic [CNT_W-1:0] count_nxt;

`ifdef IR_REPEAT_FILTER_EN
    logic [7:0]       last_key;
`endif

    always_comb begin
        full = (Count == CNT_W'(DEPTH));
        pop  = KeyValid && KeyAck;
`ifdef IR_REPEAT_FILTER_EN
        repeat_hit = (state == HOLD) && (KeyIn == last_key);
`else
        repeat_hit = 1'b0;
`endif
        // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
        push = KeyReady && !repeat_hit && (!full || pop);
        drop = KeyReady && !repeat_hit && full && !pop;

        count_nxt = Count;
        if (push && !pop)
            count_nxt = Count + CNT_W'(1);
        else if (pop && !push)
            count_nxt = Count - CNT_W'(1);
    end

    always_ff @(posedge Clock) begin
        if (!Reset && push)
            mem[wr_ptr] <= KeyIn;
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            Count    <= '0;
            KeyValid <= 1'b0;
            Overflow <= 1'b0;
            hold_cnt <= '0;
            state    <= IDLE;
`ifdef IR_REPEAT_FILTER_EN
            last_key <= '0;
`endif
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PW'(1);
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            Count    <= count_nxt;
            KeyValid <= (count_nxt != '0);
            if (drop)
                Overflow <= 1'b1;

            // Any strobe (pushed, dropped or filtered) restarts the window.
            if (KeyReady) begin
                hold_cnt <= HW'(HOLD_CYCLES - 1);
                state    <= HOLD;
`ifdef IR_REPEAT_FILTER_EN
                last_key <= KeyIn;
`endif
            end else begin
                case (state)
                    HOLD: begin
                        hold_cnt <= hold_cnt - HW'(1);
                        if (hold_cnt == HW'(1))
                            state <= IDLE;
                    end
                    default: begin
                        hold_cnt <= '0;
                        state    <= IDLE;
                    end
                endcase
            end
        end
    end

    assign KeyOut = KeyValid ? mem[rd_ptr] : '0;

endmodule

// File: tb/tb_ir_key_scheduler.sv
// Self-checking bench for ir_key_scheduler: directed vector table, hold-window sequence, random run vs. a queue model.
module tb_ir_key_scheduler;

    localparam int DEPTH = 4;
    localparam int HOLD  = 8;
`ifdef IR_REPEAT_FILTER_EN
    localparam bit FILT = 1'b1;
`else
    localparam bit FILT = 1'b0;
`endif

    logic       Clock = 1'b0;
    logic       Reset;
    logic [7:0] KeyIn;
    logic       KeyReady;
    logic [7:0] KeyOut;
    logic       KeyValid;
    logic       KeyAck;
    logic [2:0] Count;
    logic       Overflow;

    int errors = 0;
    int checks = 0;

    ir_key_scheduler #(.DEPTH(DEPTH), .HOLD_CYCLES(HOLD)) dut (
        .Clock   (Clock),
        .Reset   (Reset),
        .KeyIn   (KeyIn),
        .KeyReady(KeyReady),
        .KeyOut  (KeyOut),
        .KeyValid(KeyValid),
        .KeyAck  (KeyAck),
        .Count   (Count),
        .Overflow(Overflow)
    );

    always #5 Clock = ~Clock;

    // Reference model: a byte queue plus the cycle index of the last strobe.
    logic [7:0] mq[$];
    bit         m_ovf;
    bit         m_have_prev;
    int         m_last_cyc;
    logic [7:0] m_last_code;
    int         cyc = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle=%0d actual=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    task automatic model_step(input bit r, input bit s, input logic [7:0] k, input bit a);
        bit pop;
        bit filt;
        cyc++;
        if (r) begin
            mq.delete();
            m_ovf = 0;
            m_have_prev = 0;
            return;
        end
        pop  = (mq.size() != 0) && a;
        filt = FILT && s && m_have_prev && ((cyc - m_last_cyc) < HOLD) && (k == m_last_code);
        if (pop)
            void'(mq.pop_front());
        if (s && !filt) begin
            if (mq.size() < DEPTH)
                mq.push_back(k);
            else
                m_ovf = 1;
        end
        if (s) begin
            m_last_cyc  = cyc;
            m_last_code = k;
            m_have_prev = 1;
        end
    endtask

    task automatic step(input bit r, input bit s, input logic [7:0] k, input bit a);
        Reset    = r;
        KeyReady = s;
        KeyIn    = k;
        KeyAck   = a;
        @(posedge Clock);
        model_step(r, s, k, a);
        #1;
        check("model_valid", int'(KeyValid), int'(mq.size() != 0));
        check("model_out",   int'(KeyOut),   (mq.size() != 0) ? int'(mq[0]) : 0);
        check("model_count", int'(Count),    mq.size());
        check("model_ovf",   int'(Overflow), int'(m_ovf));
    endtask

    typedef struct {
        bit         rst;
        bit         rdy;
        logic [7:0] key;
        bit         ack;
        bit         valid;
        logic [7:0] out;
        int         cnt;
        bit         ovf;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t v(bit rst, bit rdy, logic [7:0] key, bit ack,
                               bit valid, logic [7:0] out, int cnt, bit ovf);
        vec_t t;
        t.rst = rst; t.rdy = rdy; t.key = key; t.ack = ack;
        t.valid = valid; t.out = out; t.cnt = cnt; t.ovf = ovf;
        return t;
    endfunction

    initial begin
        Reset = 1'b1; KeyReady = 1'b0; KeyIn = '0; KeyAck = 1'b0;

        // Single key, ack clears it
        tbl.push_back(v(1, 0, 8'h00, 0, 0, 8'h00, 0, 0));
        tbl.push_back(v(0, 1, 8'h01, 0, 1, 8'h01, 1, 0));
        tbl.push_back(v(0, 0, 8'h00, 0, 1, 8'h01, 1, 0));
        tbl.push_back(v(0, 0, 8'h00, 1, 0, 8'h00, 0, 0));
        // Repeat filter
        tbl.push_back(v(1, 0, 8'h00, 0, 0, 8'h00, 0, 0));
        tbl.push_back(v(0, 1, 8'h16, 0, 1, 8'h16, 1, 0));
        tbl.push_back(v(0, 0, 8'h00, 0, 1, 8'h16, 1, 0));
        tbl.push_back(v(0, 0, 8'h00, 0, 1, 8'h16, 1, 0));
        tbl.push_back(v(0, 1, 8'h16, 0, 1, 8'h16, FILT ? 1 : 2, 0));
        for (int i = 0; i < 9; i++)
            tbl.push_back(v(0, 0, 8'h00, 0, 1, 8'h16, FILT ? 1 : 2, 0));
        tbl.push_back(v(0, 1, 8'h16, 0, 1, 8'h16, FILT ? 2 : 3, 0));
        tbl.push_back(v(0, 0, 8'h00, 1, 1, 8'h16, FILT ? 1 : 2, 0));
        tbl.push_back(v(0, 0, 8'h00, 1, !FILT, FILT ? 8'h00 : 8'h16, FILT ? 0 : 1, 0));
        tbl.push_back(v(0, 0, 8'h00, 1, 0, 8'h00, 0, 0));
        // Overflow, pop order
        tbl.push_back(v(1, 0, 8'h00, 0, 0, 8'h00, 0, 0));
        tbl.push_back(v(0, 1, 8'h01, 0, 1, 8'h01, 1, 0));
        tbl.push_back(v(0, 1, 8'h02, 0, 1, 8'h01, 2, 0));
        tbl.push_back(v(0, 1, 8'h03, 0, 1, 8'h01, 3, 0));
        tbl.push_back(v(0, 1, 8'h04, 0, 1, 8'h01, 4, 0));
        tbl.push_back(v(0, 1, 8'h05, 0, 1, 8'h01, 4, 1));
        tbl.push_back(v(0, 0, 8'h00, 1, 1, 8'h02, 3, 1));
        tbl.push_back(v(0, 0, 8'h00, 1, 1, 8'h03, 2, 1));
        tbl.push_back(v(0, 0, 8'h00, 1, 1, 8'h04, 1, 1));
        tbl.push_back(v(0, 0, 8'h00, 1, 0, 8'h00, 0, 1));
        // Full with simultaneous push and pop
        tbl.push_back(v(1, 0, 8'h00, 0, 0, 8'h00, 0, 0));
        tbl.push_back(v(0, 1, 8'h01, 0, 1, 8'h01, 1, 0));
        tbl.push_back(v(0, 1, 8'h02, 0, 1, 8'h01, 2, 0));
        tbl.push_back(v(0, 1, 8'h03, 0, 1, 8'h01, 3, 0));
        tbl.push_back(v(0, 1, 8'h04, 0, 1, 8'h01, 4, 0));
        tbl.push_back(v(0, 1, 8'h07, 1, 1, 8'h02, 4, 0));
        tbl.push_back(v(0, 0, 8'h00, 1, 1, 8'h03, 3, 0));
        tbl.push_back(v(0, 0, 8'h00, 1, 1, 8'h04, 2, 0));
        tbl.push_back(v(0, 0, 8'h00, 1, 1, 8'h07, 1, 0));
        tbl.push_back(v(0, 0, 8'h00, 1, 0, 8'h00, 0, 0));
        // Reset wins over a same-cycle strobe; next strobe of same key accepted
        tbl.push_back(v(1, 0, 8'h00, 0, 0, 8'h00, 0, 0));
        tbl.push_back(v(0, 1, 8'h10, 0, 1, 8'h10, 1, 0));
        tbl.push_back(v(0, 1, 8'h20, 0, 1, 8'h10, 2, 0));
        tbl.push_back(v(0, 1, 8'h45, 0, 1, 8'h10, 3, 0));
        tbl.push_back(v(1, 1, 8'h45, 0, 0, 8'h00, 0, 0));
        tbl.push_back(v(0, 1, 8'h45, 0, 1, 8'h45, 1, 0));
        tbl.push_back(v(0, 0, 8'h00, 1, 0, 8'h00, 0, 0));
        // Back-to-back acks, ack while empty, push while empty with ack
        tbl.push_back(v(0, 1, 8'h61, 0, 1, 8'h61, 1, 0));
        tbl.push_back(v(0, 1, 8'h62, 0, 1, 8'h61, 2, 0));
        tbl.push_back(v(0, 1, 8'h63, 0, 1, 8'h61, 3, 0));
        tbl.push_back(v(0, 1, 8'h64, 0, 1, 8'h61, 4, 0));
        tbl.push_back(v(0, 0, 8'h00, 1, 1, 8'h62, 3, 0));
        tbl.push_back(v(0, 0, 8'h00, 1, 1, 8'h63, 2, 0));
        tbl.push_back(v(0, 0, 8'h00, 1, 1, 8'h64, 1, 0));
        tbl.push_back(v(0, 0, 8'h00, 1, 0, 8'h00, 0, 0));
        tbl.push_back(v(0, 0, 8'h00, 1, 0, 8'h00, 0, 0));
        tbl.push_back(v(0, 1, 8'h70, 1, 1, 8'h70, 1, 0));
        tbl.push_back(v(0, 0, 8'h00, 1, 0, 8'h00, 0, 0));

        foreach (tbl[i]) begin
            step(tbl[i].rst, tbl[i].rdy, tbl[i].key, tbl[i].ack);
            check("vec_valid", int'(KeyValid), int'(tbl[i].valid));
            check("vec_out",   int'(KeyOut),   int'(tbl[i].out));
            check("vec_count", int'(Count),    tbl[i].cnt);
            check("vec_ovf",   int'(Overflow), int'(tbl[i].ovf));
        end

        // Hold-window boundary: distance HOLD-1 is filtered, distance HOLD is accepted
        step(1, 0, 8'h00, 0);
        step(0, 1, 8'h33, 0);
        for (int i = 0; i < HOLD - 2; i++)
            step(0, 0, 8'h00, 0);
        step(0, 1, 8'h33, 0);
        check("hold_edge_in", int'(Count), FILT ? 1 : 2);
        for (int i = 0; i < HOLD - 1; i++)
            step(0, 0, 8'h00, 0);
        step(0, 1, 8'h33, 0);
        check("hold_edge_out", int'(Count), FILT ? 2 : 3);
        step(0, 1, 8'h34, 0);
        check("hold_other_key", int'(Count), FILT ? 3 : 4);

        // Randomized run against the model
        step(1, 0, 8'h00, 0);
        for (int i = 0; i < 4000; i++) begin
            bit r;
            bit s;
            bit a;
            logic [7:0] k;
            r = ($urandom_range(0, 249) == 0);
            s = ($urandom_range(0, 2) == 0);
            k = 8'($urandom_range(0, 3));
            if ((i / 300) % 2 == 0)
                a = ($urandom_range(0, 5) == 0);
            else
                a = ($urandom_range(0, 1) == 0);
            step(r, s, k, a);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
